// File: rtl/imuldiv_seq_if.sv
// Handshake bundle between decode/execute and the multiply/divide sequencer.
`ifndef CPU_IMDOP_WIDTH
`define CPU_IMDOP_WIDTH 4
`define CPU_IMDOP_IDLE  4'd0
`define CPU_IMDOP_MUL   4'd1
`define CPU_IMDOP_MULU  4'd2
`define CPU_IMDOP_DIV   4'd3
`define CPU_IMDOP_DIVU  4'd4
`define CPU_IMDOP_MFHI  4'd5
`define CPU_IMDOP_MFLO  4'd6
`define CPU_IMDOP_MTHI  4'd7
`define CPU_IMDOP_MTLO  4'd8
`endif

interface imuldiv_seq_if;
  logic [`CPU_IMDOP_WIDTH-1:0] i_op;
  logic [31:0]                 i_rs;
  logic [31:0]                 i_rt;
  logic                        i_ext_stall;
  logic                        i_nullify;
  logic                        o_stall;
  logic [31:0]                 o_result;
  logic                        o_busy;

  modport master (
    output i_op, i_rs, i_rt, i_ext_stall, i_nullify,
    input  o_stall, o_result, o_busy
  );

  modport slave (
    input  i_op, i_rs, i_rt, i_ext_stall, i_nullify,
    output o_stall, o_result, o_busy
  );
endinterface

// File: rtl/imuldiv_seq.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
// Multiplies use 32 shift-add steps (or one array multiply when FAST_MUL=1),
// divides use 32 restoring steps, both followed by one sign-fix cycle.
`ifndef CPU_IMDOP_WIDTH
`define CPU_IMDOP_WIDTH 4
`define CPU_IMDOP_IDLE  4'd0
`define CPU_IMDOP_MUL   4'd1
`define CPU_IMDOP_MULU  4'd2
`define CPU_IMDOP_DIV   4'd3
`define CPU_IMDOP_DIVU  4'd4
`define CPU_IMDOP_MFHI  4'd5
`define CPU_IMDOP_MFLO  4'd6
`define CPU_IMDOP_MTHI  4'd7
`define CPU_IMDOP_MTLO  4'd8
`endif

module imuldiv_seq #(
  parameter int FAST_MUL = 0
) (
  input logic          clk,
  input logic          rst,
  imuldiv_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;

  // Multiply datapath: accumulator, shifting multiplicand, shifting multiplier
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;

  // Divide datapath: remainder, dividend/quotient shift register, divisor
  logic [31:0] rem;
  logic [31:0] quot;
  logic [31:0] dvsr;

  logic        neg_res;
  logic        neg_rem;
  logic        is_div;

  logic        op_v;
  logic        op_signed;
  logic        op_stallable;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] mul_next;
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // Issue decode, operand magnitudes and the one-cycle array products
  always_comb begin
    op_v      = (bus.i_op != `CPU_IMDOP_IDLE) && !bus.i_nullify && !bus.i_ext_stall;
    op_signed = (bus.i_op == `CPU_IMDOP_MUL) || (bus.i_op == `CPU_IMDOP_DIV);
    op_stallable = 1'b0;
    case (bus.i_op)
      `CPU_IMDOP_MUL, `CPU_IMDOP_MULU, `CPU_IMDOP_DIV, `CPU_IMDOP_DIVU,
      `CPU_IMDOP_MFHI, `CPU_IMDOP_MFLO, `CPU_IMDOP_MTHI, `CPU_IMDOP_MTLO:
        op_stallable = 1'b1;
      default: op_stallable = 1'b0;
    endcase
    abs_a  = (op_signed && bus.i_rs[31]) ? (32'd0 - bus.i_rs) : bus.i_rs;
    abs_b  = (op_signed && bus.i_rt[31]) ? (32'd0 - bus.i_rt) : bus.i_rt;
    prod_s = $signed({{32{bus.i_rs[31]}}, bus.i_rs}) * $signed({{32{bus.i_rt[31]}}, bus.i_rt});
    prod_u = {32'd0, bus.i_rs} * {32'd0, bus.i_rt};
  end

  // Per-cycle iteration steps and the final sign correction
  always_comb begin
    mul_next = mplier[0] ? (acc + mcand) : acc;
    rem_sh   = {rem, quot[31]};
    rem_diff = rem_sh - {1'b0, dvsr};
    prod_fix = neg_res ? (64'd0 - acc) : acc;
    quot_fix = neg_res ? (32'd0 - quot) : quot;
    rem_fix  = neg_rem ? (32'd0 - rem) : rem;
  end

  // Status and read-data outputs
  always_comb begin
    bus.o_busy   = (state != ST_IDLE);
    bus.o_stall  = (state != ST_IDLE) && op_stallable && !bus.i_nullify;
    bus.o_result = (bus.i_op == `CPU_IMDOP_MFHI) ? hi : lo;
  end

  // Sequencer: accept ops in IDLE, iterate, then fix signs and write HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 5'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      acc     <= 64'd0;
      mcand   <= 64'd0;
      mplier  <= 32'd0;
      rem     <= 32'd0;
      quot    <= 32'd0;
      dvsr    <= 32'd0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      is_div  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_v) begin
            case (bus.i_op)
              `CPU_IMDOP_MUL, `CPU_IMDOP_MULU: begin
                if (FAST_MUL != 0) begin
                  {hi, lo} <= op_signed ? prod_s : prod_u;
                end else begin
                  acc     <= 64'd0;
                  mcand   <= {32'd0, abs_a};
                  mplier  <= abs_b;
                  neg_res <= op_signed && (bus.i_rs[31] ^ bus.i_rt[31]);
                  neg_rem <= 1'b0;
                  is_div  <= 1'b0;
                  cnt     <= 5'd0;
                  state   <= ST_MUL;
                end
              end
              `CPU_IMDOP_DIV, `CPU_IMDOP_DIVU: begin
                rem     <= 32'd0;
                quot    <= abs_a;
                dvsr    <= abs_b;
                neg_res <= op_signed && (bus.i_rs[31] ^ bus.i_rt[31]);
                neg_rem <= op_signed && bus.i_rs[31];
                is_div  <= 1'b1;
                cnt     <= 5'd0;
                state   <= ST_DIV;
              end
              `CPU_IMDOP_MTHI: hi <= bus.i_rs;
              `CPU_IMDOP_MTLO: lo <= bus.i_rs;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          acc    <= mul_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) state <= ST_FIX;
        end
        ST_DIV: begin
          if (!rem_diff[32]) begin
            rem  <= rem_diff[31:0];
            quot <= {quot[30:0], 1'b1};
          end else begin
            rem  <= rem_sh[31:0];
            quot <= {quot[30:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= ST_FIX;
        end
        ST_FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imuldiv_seq.sv
// Self-checking bench for imuldiv_seq: directed corner cases plus random
// multiply/divide/move traffic checked against an arithmetic HI/LO model.
`ifndef CPU_IMDOP_WIDTH
`define CPU_IMDOP_WIDTH 4
`define CPU_IMDOP_IDLE  4'd0
`define CPU_IMDOP_MUL   4'd1
`define CPU_IMDOP_MULU  4'd2
`define CPU_IMDOP_DIV   4'd3
`define CPU_IMDOP_DIVU  4'd4
`define CPU_IMDOP_MFHI  4'd5
`define CPU_IMDOP_MFLO  4'd6
`define CPU_IMDOP_MTHI  4'd7
`define CPU_IMDOP_MTLO  4'd8
`endif

module tb_imuldiv_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  imuldiv_seq_if bus ();

  imuldiv_seq #(.FAST_MUL(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference HI/LO result straight from the arithmetic definition
  task automatic refModel(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    h = hi_m;
    l = lo_m;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    case (op)
      `CPU_IMDOP_MUL: begin
        p = 64'(sa * sb);
        h = p[63:32];
        l = p[31:0];
      end
      `CPU_IMDOP_MULU: begin
        p = {32'd0, rs} * {32'd0, rt};
        h = p[63:32];
        l = p[31:0];
      end
      `CPU_IMDOP_DIV: begin
        if (rt == 32'd0) begin
          h = rs;
          l = (sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          h = 32'(sr);
          l = 32'(sq);
        end
      end
      `CPU_IMDOP_DIVU: begin
        if (rt == 32'd0) begin
          h = rs;
          l = 32'hFFFF_FFFF;
        end else begin
          h = rs % rt;
          l = rs / rt;
        end
      end
      `CPU_IMDOP_MTHI: h = rs;
      `CPU_IMDOP_MTLO: l = rs;
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                               input logic nul, input logic ext);
    @(negedge clk);
    bus.i_op        = op;
    bus.i_rs        = rs;
    bus.i_rt        = rt;
    bus.i_nullify   = nul;
    bus.i_ext_stall = ext;
  endtask

  // Reads HI and LO through MFHI/MFLO while idle; called just after a negedge
  task automatic readHiLo(input string tag);
    bus.i_op = `CPU_IMDOP_MFHI;
    #1;
    checkOutput({tag, "_hi"}, bus.o_result, hi_m);
    checkOutput({tag, "_hi_stall"}, {31'd0, bus.o_stall}, 32'd0);
    bus.i_op = `CPU_IMDOP_MFLO;
    #1;
    checkOutput({tag, "_lo"}, bus.o_result, lo_m);
    bus.i_op = `CPU_IMDOP_IDLE;
  endtask

  // Op already driven at a negedge: let it issue, count busy cycles, check results
  task automatic waitIter(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input string tag);
    int n;
    @(posedge clk);
    @(negedge clk);
    bus.i_op = `CPU_IMDOP_IDLE;
    bus.i_ext_stall = 1'b0;
    #1;
    checkOutput({tag, "_idle_nostall"}, {31'd0, bus.o_stall}, 32'd0);
    n = 0;
    while (bus.o_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, "_busy_cycles"}, 32'(n), 32'd33);
    refModel(op, rs, rt, hi_m, lo_m);
    readHiLo(tag);
  endtask

  task automatic runIter(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input string tag);
    applyStimulus(op, rs, rt, 1'b0, 1'b0);
    waitIter(op, rs, rt, tag);
  endtask

  initial begin
    logic [3:0]  ops [6];
    logic [31:0] rs, rt;
    logic [3:0]  op;
    int n;
    ops[0] = `CPU_IMDOP_MUL;  ops[1] = `CPU_IMDOP_MULU;
    ops[2] = `CPU_IMDOP_DIV;  ops[3] = `CPU_IMDOP_DIVU;
    ops[4] = `CPU_IMDOP_MTHI; ops[5] = `CPU_IMDOP_MTLO;

    bus.i_op = `CPU_IMDOP_IDLE;
    bus.i_rs = 32'd0;
    bus.i_rt = 32'd0;
    bus.i_nullify = 1'b0;
    bus.i_ext_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_busy", {31'd0, bus.o_busy}, 32'd0);
    readHiLo("reset");

    // Directed corner cases
    runIter(`CPU_IMDOP_MUL, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    checkOutput("mult_neg_const_lo", lo_m, 32'hFFFF_FFFA);

    applyStimulus(`CPU_IMDOP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.i_op = `CPU_IMDOP_MFHI;
    #1;
    n = 0;
    while (bus.o_stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    checkOutput("multu_stall_cycles", 32'(n), 32'd33);
    checkOutput("multu_mfhi", bus.o_result, 32'hFFFF_FFFE);
    bus.i_op = `CPU_IMDOP_MFLO;
    #1;
    checkOutput("multu_mflo", bus.o_result, 32'h0000_0001);
    bus.i_op = `CPU_IMDOP_IDLE;
    hi_m = 32'hFFFF_FFFE;
    lo_m = 32'h0000_0001;

    runIter(`CPU_IMDOP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7");
    checkOutput("div_neg7_const_lo", lo_m, 32'hFFFF_FFFD);
    runIter(`CPU_IMDOP_DIVU, 32'd7, 32'd0, "divu_zero");
    runIter(`CPU_IMDOP_DIV, 32'hFFFF_FFF9, 32'd0, "div_zero_neg");
    runIter(`CPU_IMDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    checkOutput("div_ovf_const_lo", lo_m, 32'h8000_0000);
    runIter(`CPU_IMDOP_MUL, 32'h8000_0000, 32'h8000_0000, "mult_minmin");

    applyStimulus(`CPU_IMDOP_MTHI, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    bus.i_op = `CPU_IMDOP_MFHI;
    #1;
    checkOutput("mthi_mfhi", bus.o_result, 32'h0000_1234);
    checkOutput("mthi_stall", {31'd0, bus.o_stall}, 32'd0);
    hi_m = 32'h0000_1234;

    applyStimulus(`CPU_IMDOP_DIVU, 32'd55, 32'd4, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("nullify_busy", {31'd0, bus.o_busy}, 32'd0);
    bus.i_nullify = 1'b0;
    readHiLo("nullify");

    applyStimulus(`CPU_IMDOP_DIVU, 32'd1000, 32'd7, 1'b0, 1'b1);
    repeat (3) begin
      #1;
      checkOutput("extstall_stall", {31'd0, bus.o_stall}, 32'd0);
      @(negedge clk);
      checkOutput("extstall_busy", {31'd0, bus.o_busy}, 32'd0);
    end
    bus.i_ext_stall = 1'b0;
    waitIter(`CPU_IMDOP_DIVU, 32'd1000, 32'd7, "extstall_divu");

    // Random traffic against the arithmetic model
    for (int k = 0; k < 24; k++) begin
      op = ops[$urandom_range(0, 5)];
      rs = $urandom;
      rt = $urandom;
      case ($urandom_range(0, 7))
        0: rt = 32'd0;
        1: begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
        2: rt = rt >> $urandom_range(8, 31);
        default: ;
      endcase
      if (op == `CPU_IMDOP_MTHI || op == `CPU_IMDOP_MTLO) begin
        applyStimulus(op, rs, rt, 1'b0, 1'b0);
        @(negedge clk);
        bus.i_op = `CPU_IMDOP_IDLE;
        refModel(op, rs, rt, hi_m, lo_m);
        readHiLo("rand_mt");
      end else begin
        runIter(op, rs, rt, "rand_iter");
      end
    end

    // Reset in the middle of a multiply
    applyStimulus(`CPU_IMDOP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.i_op = `CPU_IMDOP_IDLE;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_busy", {31'd0, bus.o_busy}, 32'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    readHiLo("midreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imuldiv_seq.md
Name: imuldiv_seq

Overview:
- Multi-cycle sequencer for the integer multiply/divide resource and its HI/LO register pair.
- Sits in the execute stage and consumes the imuldiv operation code produced by decode.
- Runs MULT/MULTU/DIV/DIVU iteratively and serves MFHI/MFLO/MTHI/MTLO.
- Raises a stall request while a result is not yet available.

Parameters:
- FAST_MUL, 0, 1 = multiply completes in one cycle (array multiply); 0 = iterative 32-step shift-add.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_op  in  `CPU_IMDOP_WIDTH  operation: IDLE, MUL, MULU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO (`CPU_IMDOP_* codes).
- i_rs  in  32  operand A: multiplicand, dividend, or MTHI/MTLO source.
- i_rt  in  32  operand B: multiplier or divisor.
- i_ext_stall  in  1  stall from other units; never includes o_stall.
- i_nullify  in  1  current i_op is killed; treat it as IDLE.
- o_stall  out  1  this unit stalls the core.
- o_result  out  32  MFHI/MFLO read data.
- o_busy  out  1  iterative operation in progress.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge): state IDLE, HI=0, LO=0, counter=0, o_busy=0, o_stall=0.
- Reset mid-operation aborts the operation; HI/LO read 0 afterwards.
- States: IDLE, MUL, DIV, FIX.
- Issue condition: op_v = (i_op!=IDLE) & !i_nullify & !i_ext_stall.
- Accepted in IDLE with op_v:
  - MUL/MULU, FAST_MUL=1: HI:LO <= 64-bit product at that edge; stays IDLE.
  - MUL/MULU, FAST_MUL=0: latch |A|, |B| (signed op) or raw operands, plus the sign flag; go to MUL; counter=0.
  - DIV/DIVU: latch operands as above; go to DIV.
  - MTHI/MTLO: HI or LO <= i_rs at the edge.
  - MFHI/MFLO: o_result = HI/LO combinationally in the same cycle; no state change.
- MUL state: one shift-add step per cycle, LSB of multiplier first, into a 64-bit accumulator. After step 31 (32 cycles), go to FIX.
- DIV state: one restoring step per cycle, 33-bit partial remainder, quotient MSB first. After 32 cycles, go to FIX.
- FIX state, one cycle:
  - Negate the product if signed and operand signs differ.
  - Negate the quotient if signed and operand signs differ; the remainder takes the dividend's sign.
  - Write HI/LO; go to IDLE.
- Latency: an iterative op accepted at edge T has HI/LO valid after edge T+33.
- Accepting the op and writing HI/LO never depend on i_ext_stall once the op has been accepted.
- o_busy = (state != IDLE).
- o_stall = o_busy & (i_op in {MFHI, MFLO, MTHI, MTLO, MUL, MULU, DIV, DIVU}) & !i_nullify.
  - IDLE ops during busy do not stall.
  - The stall holds until the FIX-state cycle completes; the stalled op is accepted in the first IDLE cycle.
- Divide by zero: no exception.
  - DIVU: LO=0xFFFFFFFF, HI=i_rs.
  - DIV: LO=0xFFFFFFFF if dividend >= 0, else 0x00000001; HI=dividend.
  - These values are the natural outputs of the restoring algorithm plus sign fix.
- Overflow 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0.
- i_nullify on the issue cycle: the op is discarded with no state change. i_nullify has no effect on an op already running.
- Width rules:
  - Signed magnitudes are computed as 32-bit two's-complement negation; 0x80000000 maps to unsigned 0x80000000.
  - The accumulator is 64 bits; there is no saturation.
- o_result is undefined (driven as HI or LO per i_op) when i_op is not MFHI/MFLO; it is 0 after reset.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3, FAST_MUL=0 -> o_busy for 33 cycles; then MFLO=0xFFFFFFFA, MFHI=0xFFFFFFFF.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF, then MFHI issued the next cycle -> o_stall=1 for 33 cycles; then o_result=0xFFFFFFFE; MFLO=0x00000001.
- DIV rs=-7, rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU rs=7, rt=0 -> LO=0xFFFFFFFF, HI=7.
- DIV 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0. MTHI 0x1234 then MFHI -> 0x00001234 with no stall.
- DIVU issued with i_nullify=1 -> no busy, HI/LO unchanged. DIVU issued with i_ext_stall=1 for 3 cycles -> accepted on the first cycle with stall=0.
- rst=1 at iteration 10 of a MULT -> next cycle o_busy=0, o_stall=0, MFHI=0, MFLO=0.
